core_ldst_misc_ctrl: RTL and testbench

- Sequencer for byte/halfword load/store ops (LDRH/STRH/LDRSB/LDRSH/LDRB/STRB class).
- Takes an already-decoded ldst_decode plus operand values; computes the effective address and runs one memory-bus transaction.
- Aligns, sign- or zero-extends load data; produces Rd and Rn (base writeback) register writes.
- Sits between the decode/issue stage and the core data-bus port.

---
 rtl/core_ldst_misc_ctrl_pkg.sv | 29 ++
 rtl/core_ldst_misc_ctrl_lane.sv | 51 +++++
 rtl/core_ldst_misc_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_core_ldst_misc_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ldst_misc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_ldst_misc_ctrl_pkg
//   Shared core micro-architecture types used by the misc load/store sequencer:
//   the data word, register number, access size and the decoded op bundle.
//   No ports (package only).
// -----------------------------------------------------------------------------
package core_ldst_misc_ctrl_pkg;

    typedef logic [31:0] word;
    typedef logic [3:0]  reg_num;

    typedef enum logic {
        LDST_BYTE = 1'b0,
        LDST_HALF = 1'b1
    } ldst_size_e;

    // Decoded byte/halfword load/store; only the fields the sequencer needs.
    typedef struct packed {
        reg_num     rn;
        reg_num     rd;
        ldst_size_e size;
        logic       load;
        logic       increment;
        logic       writeback;
        logic       sign_extend;
        logic       pre_indexed;
    } ldst_decode;

endpackage

// File: rtl/core_ldst_misc_ctrl_lane.sv
// -----------------------------------------------------------------------------
// core_ldst_misc_lane
//   Combinational lane steering for byte/halfword accesses on a 32-bit
//   little-endian bus. Instantiated once for stores (byte enables and
//   replicated write data) and once for loads (lane extraction + extension).
// Ports:
//   ea_lo       in   low two bits of the effective address
//   size        in   LDST_BYTE / LDST_HALF
//   sign_extend in   sign- (1) or zero- (0) extend the extracted lane
//   data        in   store data (store use) or captured bus data (load use)
//   byteenable  out  lane mask
//   data_wr     out  data replicated across all lanes of the access size
//   rd_value    out  selected lane of data, extended to 32 bits
// -----------------------------------------------------------------------------
module core_ldst_misc_lane
    import core_ldst_misc_ctrl_pkg::*;
(
    input  logic [1:0]  ea_lo,
    input  ldst_size_e  size,
    input  logic        sign_extend,
    input  word         data,
    output logic [3:0]  byteenable,
    output word         data_wr,
    output word         rd_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output gets a default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        byteenable = 4'b0000;
        data_wr    = '0;
        rd_value   = '0;
        w_byte     = data[{ea_lo, 3'b000} +: 8];
        w_half     = ea_lo[1] ? data[31:16] : data[15:0];

        if (size == LDST_BYTE) begin
            byteenable = 4'b0001 << ea_lo;
            data_wr    = {4{data[7:0]}};
            rd_value   = {{24{sign_extend & w_byte[7]}}, w_byte};
        end else begin
            // ea_lo[0] is deliberately ignored for halfwords.
            byteenable = ea_lo[1] ? 4'b1100 : 4'b0011;
            data_wr    = {2{data[15:0]}};
            rd_value   = {{16{sign_extend & w_half[15]}}, w_half};
        end
    end

endmodule

// File: rtl/core_ldst_misc_ctrl.sv
// -----------------------------------------------------------------------------
// core_ldst_misc_ctrl
//   Sequencer for byte/halfword load/store ops. Latches a decoded op, computes
//   the effective address, runs one data-bus transaction and produces the Rd
//   (load result) and Rn (base writeback) register writes.
//   Flow: IDLE -> ISSUE -> WAIT -> COMMIT -> IDLE.
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   start, decode              issue request (IDLE only) and decoded op
//   base, offset, store_data   Rn value, resolved offset, Rd value for stores
//   busy                       high in every state except IDLE
//   bus_*                      data-bus request/response
//   rd_we, rd_num, rd_value    load result write
//   rn_we, rn_value            base writeback
//   done                       one-cycle completion pulse
//   align_fault                (only with CORE_LDST_ALIGN_FAULT_EN) pulses with
//                              done for an odd-address halfword, which then
//                              skips the bus and writes no register.
// Build option: define CORE_LDST_ALIGN_FAULT_EN to enable alignment faults.
// -----------------------------------------------------------------------------
module core_ldst_misc_ctrl
    import core_ldst_misc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  ldst_decode  decode,
    input  word         base,
    input  word         offset,
    input  word         store_data,
    output logic        busy,
    output logic        bus_start,
    output logic        bus_write,
    output word         bus_addr,
    output logic [3:0]  bus_byteenable,
    output word         bus_data_wr,
    input  word         bus_data_rd,
    input  logic        bus_ready,
    output logic        rd_we,
    output reg_num      rd_num,
    output word         rd_value,
    output logic        rn_we,
    output word         rn_value,
`ifdef CORE_LDST_ALIGN_FAULT_EN
    output logic        align_fault,
`endif
    output logic        done
);

    typedef enum logic [1:0] {
        LDST_MISC_IDLE,
        LDST_MISC_ISSUE,
        LDST_MISC_WAIT,
        LDST_MISC_COMMIT
    } state_e;

    state_e      r_state;
    state_e      w_next;

    reg_num      r_rn;
    reg_num      r_rd;
    ldst_size_e  r_size;
    logic        r_load;
    logic        r_writeback;
    logic        r_sign_extend;
    logic        r_fault;
    word         r_ea;
    word         r_upd;
    word         r_store_data;
    word         r_rdata;

    word         w_upd;
    word         w_ea;
    logic        w_fault;
    logic [3:0]  w_st_be;
    word         w_st_data;
    word         w_ld_value;
    logic [3:0]  w_unused_ld_be;
    word         w_unused_ld_wr;
    word         w_unused_st_rd;

    assign w_upd = decode.increment ? (base + offset) : (base - offset);
    assign w_ea  = decode.pre_indexed ? w_upd : base;

`ifdef CORE_LDST_ALIGN_FAULT_EN
    assign w_fault = (decode.size == LDST_HALF) && w_ea[0];
`else
    assign w_fault = 1'b0;
`endif

    core_ldst_misc_lane u_store_lane (
        .ea_lo       (r_ea[1:0]),
        .size        (r_size),
        .sign_extend (1'b0),
        .data        (r_store_data),
        .byteenable  (w_st_be),
        .data_wr     (w_st_data),
        .rd_value    (w_unused_st_rd)
    );

    core_ldst_misc_lane u_load_lane (
        .ea_lo       (r_ea[1:0]),
        .size        (r_size),
        .sign_extend (r_sign_extend),
        .data        (r_rdata),
        .byteenable  (w_unused_ld_be),
        .data_wr     (w_unused_ld_wr),
        .rd_value    (w_ld_value)
    );

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LDST_MISC_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand latch; cleared on reset so an abandoned op leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rn          <= '0;
            r_rd          <= '0;
            r_size        <= LDST_BYTE;
            r_load        <= 1'b0;
            r_writeback   <= 1'b0;
            r_sign_extend <= 1'b0;
            r_fault       <= 1'b0;
            r_ea          <= '0;
            r_upd         <= '0;
            r_store_data  <= '0;
            r_rdata       <= '0;
        end else begin
            if (r_state == LDST_MISC_IDLE && start) begin
                r_rn          <= decode.rn;
                r_rd          <= decode.rd;
                r_size        <= decode.size;
                r_load        <= decode.load;
                r_writeback   <= decode.writeback;
                r_sign_extend <= decode.sign_extend;
                r_fault       <= w_fault;
                r_ea          <= w_ea;
                r_upd         <= w_upd;
                r_store_data  <= store_data;
            end
            if (r_state == LDST_MISC_WAIT && bus_ready) begin
                r_rdata <= bus_data_rd;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        busy           = 1'b0;
        bus_start      = 1'b0;
        bus_write      = 1'b0;
        bus_addr       = '0;
        bus_byteenable = 4'b0000;
        bus_data_wr    = '0;
        rd_we          = 1'b0;
        rd_num         = '0;
        rd_value       = '0;
        rn_we          = 1'b0;
        rn_value       = '0;
        done           = 1'b0;
`ifdef CORE_LDST_ALIGN_FAULT_EN
        align_fault    = 1'b0;
`endif

        case (r_state)
            LDST_MISC_IDLE: begin
                if (start) begin
                    w_next = w_fault ? LDST_MISC_COMMIT : LDST_MISC_ISSUE;
                end
            end
            LDST_MISC_ISSUE, LDST_MISC_WAIT: begin
                busy           = 1'b1;
                bus_start      = (r_state == LDST_MISC_ISSUE);
                bus_write      = !r_load;
                bus_addr       = {r_ea[31:2], 2'b00};
                bus_byteenable = w_st_be;
                bus_data_wr    = w_st_data;
                // bus_ready is only honoured in WAIT; ISSUE always advances.
                if (r_state == LDST_MISC_ISSUE) begin
                    w_next = LDST_MISC_WAIT;
                end else if (bus_ready) begin
                    w_next = LDST_MISC_COMMIT;
                end
            end
            LDST_MISC_COMMIT: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = LDST_MISC_IDLE;
`ifdef CORE_LDST_ALIGN_FAULT_EN
                align_fault = r_fault;
`endif
                if (!r_fault) begin
                    rd_we    = r_load;
                    rd_num   = r_load ? r_rd : '0;
                    rd_value = r_load ? w_ld_value : '0;
                    // A load into its own base register keeps the loaded value.
                    rn_we    = r_writeback && !(r_load && (r_rn == r_rd));
                    rn_value = r_upd;
                end
            end
            default: w_next = LDST_MISC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_ldst_misc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_ldst_misc_ctrl
//   Directed bench for core_ldst_misc_ctrl. A negedge monitor records bus
//   strobes and completion values; a negedge responder answers each bus_start
//   after a programmable number of wait cycles. Expected values are written
//   out by hand in each test task.
// -----------------------------------------------------------------------------
module tb_core_ldst_misc_ctrl;
    import core_ldst_misc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    ldst_decode  decode;
    word         base, offset, store_data;
    logic        busy, bus_start, bus_write;
    word         bus_addr;
    logic [3:0]  bus_byteenable;
    word         bus_data_wr;
    word         bus_data_rd;
    logic        bus_ready;
    logic        rd_we;
    reg_num      rd_num;
    word         rd_value;
    logic        rn_we;
    word         rn_value;
    logic        done;
    logic        fault_sig;

    core_ldst_misc_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .decode         (decode),
        .base           (base),
        .offset         (offset),
        .store_data     (store_data),
        .busy           (busy),
        .bus_start      (bus_start),
        .bus_write      (bus_write),
        .bus_addr       (bus_addr),
        .bus_byteenable (bus_byteenable),
        .bus_data_wr    (bus_data_wr),
        .bus_data_rd    (bus_data_rd),
        .bus_ready      (bus_ready),
        .rd_we          (rd_we),
        .rd_num         (rd_num),
        .rd_value       (rd_value),
        .rn_we          (rn_we),
        .rn_value       (rn_value),
`ifdef CORE_LDST_ALIGN_FAULT_EN
        .align_fault    (fault_sig),
`endif
        .done           (done)
    );

`ifndef CORE_LDST_ALIGN_FAULT_EN
    assign fault_sig = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Monitor state
    int n_bus_start = 0, n_done = 0, n_rd_we = 0, n_rn_we = 0, n_hold_err = 0;
    int m_bs_cyc = 0, m_done_cyc = 0;
    word m_addr = '0, m_wdata = '0, m_rd_value = '0, m_rn_value = '0;
    logic [3:0] m_be = '0;
    logic m_write = 1'b0, m_rd_we = 1'b0, m_rn_we = 1'b0, m_fault = 1'b0;
    reg_num m_rd_num = '0;

    always @(negedge clk) begin
        if (bus_start) begin
            n_bus_start++;
            m_bs_cyc = cyc;
            m_addr   = bus_addr;
            m_be     = bus_byteenable;
            m_wdata  = bus_data_wr;
            m_write  = bus_write;
        end else if (busy && !done &&
                     (bus_addr !== m_addr || bus_byteenable !== m_be ||
                      bus_data_wr !== m_wdata || bus_write !== m_write)) begin
            n_hold_err++;
        end
        if (rd_we) n_rd_we++;
        if (rn_we) n_rn_we++;
        if (done) begin
            n_done++;
            m_done_cyc = cyc;
            m_rd_we    = rd_we;
            m_rd_num   = rd_num;
            m_rd_value = rd_value;
            m_rn_we    = rn_we;
            m_rn_value = rn_value;
            m_fault    = fault_sig;
        end
    end

    // Bus responder
    int  resp_waits = 0;
    word resp_data = '0;
    bit  pending = 1'b0;
    int  wcnt = 0;

    always @(negedge clk) begin
        bus_ready <= 1'b0;
        if (bus_start) begin
            pending = 1'b1;
            wcnt    = resp_waits;
        end else if (pending) begin
            if (wcnt == 0) begin
                bus_ready   <= 1'b1;
                bus_data_rd <= resp_data;
                pending = 1'b0;
            end else begin
                wcnt--;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic ldst_decode mk_dec(input reg_num rn, input reg_num rd,
                                          input ldst_size_e sz, input logic ld,
                                          input logic inc, input logic wb,
                                          input logic sx, input logic pre);
        ldst_decode d;
        d.rn = rn; d.rd = rd; d.size = sz; d.load = ld;
        d.increment = inc; d.writeback = wb; d.sign_extend = sx; d.pre_indexed = pre;
        return d;
    endfunction

    // Runs one op and returns start-to-done latency (-1 on timeout).
    task automatic run_op(input ldst_decode d, input word b, input word o,
                          input word sd, input word rdata, input int waits,
                          output int lat);
        int t_start;
        int base_done;
        resp_waits = waits;
        resp_data  = rdata;
        tick();
        decode = d; base = b; offset = o; store_data = sd; start = 1'b1;
        t_start   = cyc;
        base_done = n_done;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && n_done == base_done; i++) tick();
        lat = (n_done == base_done) ? -1 : (m_done_cyc - t_start);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; decode = '0; base = '0; offset = '0; store_data = '0;
        tick(); tick();
        total_cnt++;
        if ({busy, bus_start, bus_write, done, rd_we, rn_we} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, bus_start, bus_write, done, rd_we, rn_we});
        else pass_cnt++;
        total_cnt++;
        if ({bus_addr, bus_byteenable, bus_data_wr} !== '0)
            $display("FAIL reset_bus: got %h/%b/%h expected 0", bus_addr, bus_byteenable, bus_data_wr);
        else pass_cnt++;
        total_cnt++;
        if ({rd_num, rd_value, rn_value} !== '0)
            $display("FAIL reset_regs: got %h/%h/%h expected 0", rd_num, rd_value, rn_value);
        else pass_cnt++;
        rst_n = 1'b1;
        tick(); tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_ldrsb();
        int lat, bs0;
        bs0 = n_bus_start;
        run_op(mk_dec(4'd1, 4'd2, LDST_BYTE, 1, 1, 0, 1, 1), 32'h1000, 32'd3, 32'h0, 32'h80FF_FF00, 0, lat);
        total_cnt++; if (lat !== 3) $display("FAIL ldrsb_latency: got %0d expected 3", lat); else pass_cnt++;
        total_cnt++; if (n_bus_start - bs0 !== 1) $display("FAIL ldrsb_strobes: got %0d expected 1", n_bus_start - bs0); else pass_cnt++;
        total_cnt++; if (m_addr !== 32'h1000) $display("FAIL ldrsb_addr: got %h expected 00001000", m_addr); else pass_cnt++;
        total_cnt++; if (m_be !== 4'b1000) $display("FAIL ldrsb_be: got %b expected 1000", m_be); else pass_cnt++;
        total_cnt++; if (m_write !== 1'b0) $display("FAIL ldrsb_write: got %b expected 0", m_write); else pass_cnt++;
        total_cnt++;
        if ({m_rd_we, m_rd_num, m_rd_value} !== {1'b1, 4'd2, 32'hFFFF_FF80})
            $display("FAIL ldrsb_rd: got %b/%h/%h expected 1/2/ffffff80", m_rd_we, m_rd_num, m_rd_value);
        else pass_cnt++;
        total_cnt++; if (m_rn_we !== 1'b0) $display("FAIL ldrsb_rn_we: got %b expected 0", m_rn_we); else pass_cnt++;
    endtask

    task automatic test_strh();
        int lat;
        run_op(mk_dec(4'd3, 4'd4, LDST_HALF, 0, 0, 1, 0, 0), 32'h2002, 32'd4, 32'h1234_ABCD, 32'h0, 0, lat);
        total_cnt++; if (lat !== 3) $display("FAIL strh_latency: got %0d expected 3", lat); else pass_cnt++;
        total_cnt++; if (m_addr !== 32'h2000) $display("FAIL strh_addr: got %h expected 00002000", m_addr); else pass_cnt++;
        total_cnt++; if (m_be !== 4'b1100) $display("FAIL strh_be: got %b expected 1100", m_be); else pass_cnt++;
        total_cnt++; if (m_wdata !== 32'hABCD_ABCD) $display("FAIL strh_data: got %h expected abcdabcd", m_wdata); else pass_cnt++;
        total_cnt++; if (m_write !== 1'b1) $display("FAIL strh_write: got %b expected 1", m_write); else pass_cnt++;
        total_cnt++; if (m_rd_we !== 1'b0) $display("FAIL strh_rd_we: got %b expected 0", m_rd_we); else pass_cnt++;
        total_cnt++;
        if ({m_rn_we, m_rn_value} !== {1'b1, 32'h0000_1FFE})
            $display("FAIL strh_rn: got %b/%h expected 1/00001ffe", m_rn_we, m_rn_value);
        else pass_cnt++;
    endtask

    task automatic test_ldrh_wait();
        int lat, h0;
        h0 = n_hold_err;
        run_op(mk_dec(4'd5, 4'd5, LDST_HALF, 1, 1, 1, 0, 1), 32'h4000, 32'd4, 32'h0, 32'h0000_8001, 3, lat);
        total_cnt++; if (lat !== 6) $display("FAIL ldrh_latency: got %0d expected 6", lat); else pass_cnt++;
        total_cnt++; if (m_addr !== 32'h4004) $display("FAIL ldrh_addr: got %h expected 00004004", m_addr); else pass_cnt++;
        total_cnt++; if (m_be !== 4'b0011) $display("FAIL ldrh_be: got %b expected 0011", m_be); else pass_cnt++;
        total_cnt++; if (n_hold_err - h0 !== 0) $display("FAIL ldrh_hold: got %0d unstable cycles expected 0", n_hold_err - h0); else pass_cnt++;
        total_cnt++;
        if ({m_rd_we, m_rd_value} !== {1'b1, 32'h0000_8001})
            $display("FAIL ldrh_rd: got %b/%h expected 1/00008001", m_rd_we, m_rd_value);
        else pass_cnt++;
        total_cnt++; if (m_rn_we !== 1'b0) $display("FAIL ldrh_rn_suppress: got %b expected 0", m_rn_we); else pass_cnt++;
    endtask

    task automatic test_lanes();
        int lat;
        // LDRSH, upper half, pre-indexed with writeback to a different register.
        run_op(mk_dec(4'd6, 4'd7, LDST_HALF, 1, 1, 1, 1, 1), 32'h0100, 32'd2, 32'h0, 32'h9234_0000, 1, lat);
        total_cnt++; if ({m_addr, m_be} !== {32'h0100, 4'b1100}) $display("FAIL ldrsh_bus: got %h/%b expected 00000100/1100", m_addr, m_be); else pass_cnt++;
        total_cnt++; if (m_rd_value !== 32'hFFFF_9234) $display("FAIL ldrsh_value: got %h expected ffff9234", m_rd_value); else pass_cnt++;
        total_cnt++; if ({m_rn_we, m_rn_value} !== {1'b1, 32'h0102}) $display("FAIL ldrsh_rn: got %b/%h expected 1/00000102", m_rn_we, m_rn_value); else pass_cnt++;
        // LDRB, lane 1, decrementing pre-index, zero-extended.
        run_op(mk_dec(4'd1, 4'd8, LDST_BYTE, 1, 0, 0, 0, 1), 32'h0105, 32'd4, 32'h0, 32'hFFFF_C5FF, 0, lat);
        total_cnt++; if ({m_addr, m_be} !== {32'h0100, 4'b0010}) $display("FAIL ldrb_bus: got %h/%b expected 00000100/0010", m_addr, m_be); else pass_cnt++;
        total_cnt++; if (m_rd_value !== 32'h0000_00C5) $display("FAIL ldrb_value: got %h expected 000000c5", m_rd_value); else pass_cnt++;
        // STRB, lane 2, post-index.
        run_op(mk_dec(4'd2, 4'd3, LDST_BYTE, 0, 1, 0, 0, 0), 32'h0202, 32'd0, 32'h1234_5655, 32'h0, 0, lat);
        total_cnt++; if ({m_addr, m_be} !== {32'h0200, 4'b0100}) $display("FAIL strb_bus: got %h/%b expected 00000200/0100", m_addr, m_be); else pass_cnt++;
        total_cnt++; if (m_wdata !== 32'h5555_5555) $display("FAIL strb_data: got %h expected 55555555", m_wdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d0, r0, n0;
        resp_waits = 4;
        resp_data  = 32'hDEAD_BEEF;
        tick();
        decode = mk_dec(4'd9, 4'd10, LDST_BYTE, 1, 1, 1, 0, 1);
        base = 32'h5000; offset = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        d0 = n_done; r0 = n_rd_we; n0 = n_rn_we;
        rst_n = 1'b0;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy_in_reset: got %b expected 0", busy); else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        total_cnt++;
        if ({n_done - d0, n_rd_we - r0, n_rn_we - n0} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL rstmid_no_commit: got done=%0d rd_we=%0d rn_we=%0d expected 0/0/0", n_done - d0, n_rd_we - r0, n_rn_we - n0);
        else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bs0, d0, d1;
        resp_waits = 0;
        resp_data  = 32'h0000_0077;
        tick();
        decode = mk_dec(4'd1, 4'd2, LDST_BYTE, 1, 1, 0, 0, 1);
        base = 32'h0600; offset = 32'd0; start = 1'b1;
        bs0 = n_bus_start; d0 = n_done;
        for (int i = 0; i < 50 && n_done == d0; i++) tick();
        d1 = m_done_cyc;
        total_cnt++; if (n_bus_start - bs0 !== 1) $display("FAIL b2b_first_strobes: got %0d expected 1", n_bus_start - bs0); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy); else pass_cnt++;
        for (int i = 0; i < 50 && n_done == d0 + 1; i++) tick();
        start = 1'b0;
        total_cnt++; if (n_bus_start - bs0 !== 2) $display("FAIL b2b_second_strobes: got %0d expected 2", n_bus_start - bs0); else pass_cnt++;
        total_cnt++; if (m_bs_cyc - d1 !== 2) $display("FAIL b2b_issue_gap: got %0d expected 2", m_bs_cyc - d1); else pass_cnt++;
        total_cnt++; if (m_done_cyc - d1 !== 4) $display("FAIL b2b_done_gap: got %0d expected 4", m_done_cyc - d1); else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (n_bus_start - bs0 !== 2) $display("FAIL b2b_no_extra: got %0d expected 2", n_bus_start - bs0); else pass_cnt++;
    endtask

`ifdef CORE_LDST_ALIGN_FAULT_EN
    task automatic test_align_fault();
        int lat, bs0, r0, n0;
        bs0 = n_bus_start; r0 = n_rd_we; n0 = n_rn_we;
        run_op(mk_dec(4'd1, 4'd2, LDST_HALF, 1, 1, 1, 0, 0), 32'h3001, 32'd2, 32'h0, 32'h0, 0, lat);
        total_cnt++; if (lat !== 1) $display("FAIL fault_latency: got %0d expected 1", lat); else pass_cnt++;
        total_cnt++; if (n_bus_start - bs0 !== 0) $display("FAIL fault_no_bus: got %0d expected 0", n_bus_start - bs0); else pass_cnt++;
        total_cnt++; if (m_fault !== 1'b1) $display("FAIL fault_flag: got %b expected 1", m_fault); else pass_cnt++;
        total_cnt++;
        if ({n_rd_we - r0, n_rn_we - n0} !== {32'd0, 32'd0})
            $display("FAIL fault_no_write: got rd_we=%0d rn_we=%0d expected 0/0", n_rd_we - r0, n_rn_we - n0);
        else pass_cnt++;
    endtask
`else
    task automatic test_half_odd();
        int lat;
        run_op(mk_dec(4'd1, 4'd2, LDST_HALF, 1, 1, 0, 0, 0), 32'h3001, 32'd0, 32'h0, 32'hAAAA_1234, 0, lat);
        total_cnt++; if ({m_addr, m_be} !== {32'h3000, 4'b0011}) $display("FAIL half_odd_bus: got %h/%b expected 00003000/0011", m_addr, m_be); else pass_cnt++;
        total_cnt++; if (m_rd_value !== 32'h0000_1234) $display("FAIL half_odd_value: got %h expected 00001234", m_rd_value); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_ldrsb();
        test_strh();
        test_ldrh_wait();
        test_lanes();
        test_reset_mid();
        test_back_to_back();
`ifdef CORE_LDST_ALIGN_FAULT_EN
        test_align_fault();
`else
        test_half_odd();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
